id_serialize_ctrl: RTL and testbench

- Parametrised serialising-instruction controller for a multi-lane decode stage.
- Detects syscall / LL / SC class ops in the decode group and kills younger lanes.
- Freezes fetch, inserts a configurable number of drain bubbles, then notifies the simulator (syscall only) and releases fetch.
- Sits beside the decoder; its kill and freeze outputs gate the ID→EXE pipeline registers and the fetch stall.

---
 rtl/id_serialize_ctrl_pkg.sv | 31 +++
 rtl/id_serialize_ctrl_if.sv | 38 +++
 rtl/id_serialize_ctrl_lane_prio_enc.sv | 30 +++
 rtl/id_serialize_ctrl.sv | 134 +++++++++++++
 tb/tb_id_serialize_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_serialize_ctrl_pkg.sv
// Shared types and helpers for the serialising-instruction controller.
// Optional feature macro: ID_SYS_ACK_EN (simulator ack handshake on NOTIFY).
package id_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_NOTIFY  = 2'd2,
    S_RELEASE = 2'd3
  } ser_state_e;

  // ALU control codes of the serialising classes, as produced by the decoder
  localparam logic [5:0] ALU_LL      = 6'h30;
  localparam logic [5:0] ALU_SC      = 6'h38;
  localparam logic [5:0] ALU_SYSCALL = 6'h0C;

  function automatic int lane_w(input int lanes);
    return (lanes <= 1) ? 1 : $clog2(lanes);
  endfunction

  // Counter is shared by the drain and the fixed-length notify phases
  function automatic int cnt_w(input int drain, input int hold);
    int a;
    int b;
    a = $clog2(drain + 1);
    b = (hold > 1) ? $clog2(hold) : 1;
    if (b > a) a = b;
    return (a < 1) ? 1 : a;
  endfunction

endpackage

// File: rtl/id_serialize_ctrl_if.sv
// Decode-group / control bundle between the decoder and id_serialize_ctrl.
// Sys_Ack_IN exists only when ID_SYS_ACK_EN is defined.
interface id_serialize_ctrl_if #(
  parameter int LANES = 2
);
  localparam int LANE_W = id_pkg::lane_w(LANES);

  logic              FLUSH;
  logic [LANES-1:0]  Valid_IN;
  logic [LANES-1:0]  Serial_IN;
  logic [LANES-1:0]  Notify_IN;
`ifdef ID_SYS_ACK_EN
  logic              Sys_Ack_IN;
`endif
  logic [LANES-1:0]  Lane_Kill_OUT;
  logic [LANES-1:0]  Lane_Marker_OUT;
  logic              WANT_FREEZE;
  logic              SYS;
  logic [LANE_W-1:0] Serial_Lane_OUT;
  logic              Busy_OUT;

  modport master (
    output FLUSH, Valid_IN, Serial_IN, Notify_IN,
`ifdef ID_SYS_ACK_EN
    output Sys_Ack_IN,
`endif
    input  Lane_Kill_OUT, Lane_Marker_OUT, WANT_FREEZE, SYS, Serial_Lane_OUT, Busy_OUT
  );

  modport slave (
    input  FLUSH, Valid_IN, Serial_IN, Notify_IN,
`ifdef ID_SYS_ACK_EN
    input  Sys_Ack_IN,
`endif
    output Lane_Kill_OUT, Lane_Marker_OUT, WANT_FREEZE, SYS, Serial_Lane_OUT, Busy_OUT
  );

endinterface

// File: rtl/id_serialize_ctrl_lane_prio_enc.sv
// Lowest-index priority encoder: found flag, binary index, one-hot select
// and the mask of all lanes younger (higher index) than the selected one.
module lane_prio_enc #(
  parameter int LANES  = 2,
  parameter int LANE_W = 1
) (
  input  logic [LANES-1:0]  req_i,
  output logic              found_o,
  output logic [LANE_W-1:0] idx_o,
  output logic [LANES-1:0]  onehot_o,
  output logic [LANES-1:0]  younger_o
);

  always_comb begin
    found_o   = 1'b0;
    idx_o     = '0;
    onehot_o  = '0;
    younger_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (found_o) begin
        younger_o[i] = 1'b1;
      end else if (req_i[i]) begin
        found_o     = 1'b1;
        idx_o       = LANE_W'(i);
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_serialize_ctrl.sv
// Serialising-instruction controller: kills younger lanes, freezes fetch,
// drains, optionally notifies the simulator, then releases fetch.
// Optional feature macro: ID_SYS_ACK_EN (NOTIFY waits for Sys_Ack_IN).
module id_serialize_ctrl
  import id_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int DRAIN    = 3,
  parameter int SYS_HOLD = 1
) (
  input logic                CLK,
  input logic                RESET,
  id_serialize_ctrl_if.slave bus
);

  localparam int LANE_W = lane_w(LANES);
  localparam int CNT_W  = cnt_w(DRAIN, SYS_HOLD);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN - 1);
`ifndef ID_SYS_ACK_EN
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(SYS_HOLD - 1);
`endif

  ser_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              notify_q, notify_d;
  logic              sys_q, sys_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [LANE_W-1:0] idx;
  logic [LANES-1:0]  onehot;
  logic [LANES-1:0]  younger;

  lane_prio_enc #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_prio (
    .req_i     (bus.Valid_IN & bus.Serial_IN),
    .found_o   (found),
    .idx_o     (idx),
    .onehot_o  (onehot),
    .younger_o (younger)
  );

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    lane_d              = lane_q;
    notify_d            = notify_q;
    bus.Lane_Kill_OUT   = '0;
    bus.Lane_Marker_OUT = '0;
    bus.WANT_FREEZE     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          bus.Lane_Kill_OUT   = younger;
          bus.Lane_Marker_OUT = onehot;
          bus.WANT_FREEZE     = 1'b1;
          state_d             = S_DRAIN;
          cnt_d               = DRAIN_LD;
          lane_d              = idx;
          notify_d            = |(bus.Notify_IN & onehot);
        end
      end
      S_DRAIN: begin
        bus.Lane_Kill_OUT = '1;
        bus.WANT_FREEZE   = 1'b1;
        if (cnt_q == '0) begin
          if (notify_q) begin
            state_d = S_NOTIFY;
`ifndef ID_SYS_ACK_EN
            cnt_d   = HOLD_LD;
`endif
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_NOTIFY: begin
        bus.Lane_Kill_OUT = '1;
        bus.WANT_FREEZE   = 1'b1;
`ifdef ID_SYS_ACK_EN
        if (bus.Sys_Ack_IN) state_d = S_RELEASE;
`else
        if (cnt_q == '0) state_d = S_RELEASE;
        else             cnt_d   = cnt_q - CNT_W'(1);
`endif
      end
      S_RELEASE: begin
        // Fetch is let go here; anything serialising in this group is dropped
        bus.Lane_Kill_OUT = '1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.FLUSH) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      lane_d   = '0;
      notify_d = 1'b0;
    end

    sys_d  = (state_d == S_NOTIFY);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lane_q   <= '0;
      notify_q <= 1'b0;
      sys_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      notify_q <= notify_d;
      sys_q    <= sys_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.SYS             = sys_q;
  assign bus.Busy_OUT        = busy_q;
  assign bus.Serial_Lane_OUT = lane_q;

endmodule

// File: tb/tb_id_serialize_ctrl.sv
// Bench for id_serialize_ctrl: vector table, corner sequences and a
// randomized run against a phase-queue reference model.
module tb_id_serialize_ctrl;
  import id_pkg::*;

  localparam int LANES    = 2;
  localparam int DRAIN    = 3;
  localparam int SYS_HOLD = 1;
  localparam int LW       = lane_w(LANES);

  localparam byte PH_D = 8'd1;  // drain bubble
  localparam byte PH_N = 8'd2;  // timed notify
  localparam byte PH_W = 8'd3;  // notify waiting for ack
  localparam byte PH_R = 8'd4;  // release

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  id_serialize_ctrl_if #(.LANES(LANES)) bus ();

  id_serialize_ctrl #(
    .LANES    (LANES),
    .DRAIN    (DRAIN),
    .SYS_HOLD (SYS_HOLD)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

`ifdef ID_SYS_ACK_EN
  logic ack_drv = 1'b0;
  assign bus.Sys_Ack_IN = ack_drv;
`endif

  byte           q[$];
  logic [LW-1:0] lane_m;

  typedef struct {
    logic [LANES-1:0] v;
    logic [LANES-1:0] s;
    logic [LANES-1:0] n;
    logic [LANES-1:0] kill;
    logic [LANES-1:0] marker;
    logic             fr;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [LANES-1:0] v, input logic [LANES-1:0] s,
                       input logic [LANES-1:0] n, input logic f);
    bus.Valid_IN  = v;
    bus.Serial_IN = s;
    bus.Notify_IN = n;
    bus.FLUSH     = f;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_ctl(input string nm, input logic [LANES-1:0] kill,
                            input logic fr, input logic sy, input logic bz);
    chk({nm, ".kill"},   bus.Lane_Kill_OUT, kill);
    chk({nm, ".freeze"}, bus.WANT_FREEZE,   fr);
    chk({nm, ".sys"},    bus.SYS,           sy);
    chk({nm, ".busy"},   bus.Busy_OUT,      bz);
  endtask

  // Reference: an accepted op schedules a list of phases, one per cycle
  function automatic int lowest_serial();
    for (int i = 0; i < LANES; i++)
      if (bus.Valid_IN[i] && bus.Serial_IN[i]) return i;
    return -1;
  endfunction

  task automatic model_out(output logic [LANES-1:0] k, output logic [LANES-1:0] m,
                           output logic fr, output logic sy, output logic bz);
    int s;
    s = lowest_serial();
    k = '0;
    m = '0;
    if (q.size() == 0) begin
      fr = (s >= 0);
      sy = 1'b0;
      bz = 1'b0;
      if (s >= 0) begin
        m[s] = 1'b1;
        for (int i = 0; i < LANES; i++) k[i] = (i > s);
      end
    end else begin
      k  = '1;
      fr = (q[0] != PH_R);
      sy = (q[0] == PH_N) || (q[0] == PH_W);
      bz = 1'b1;
    end
  endtask

  task automatic model_edge();
    int  s;
    logic hold;
    s    = lowest_serial();
    hold = 1'b0;
`ifdef ID_SYS_ACK_EN
    hold = (q.size() != 0) && (q[0] == PH_W) && !ack_drv;
`endif
    if (bus.FLUSH) begin
      q.delete();
      lane_m = '0;
    end else if (q.size() == 0) begin
      if (s >= 0) begin
        repeat (DRAIN) q.push_back(PH_D);
        if (bus.Notify_IN[s]) begin
`ifdef ID_SYS_ACK_EN
          q.push_back(PH_W);
`else
          repeat (SYS_HOLD) q.push_back(PH_N);
`endif
        end
        q.push_back(PH_R);
        lane_m = LW'(s);
      end
    end else if (!hold) begin
      void'(q.pop_front());
    end
  endtask

  initial begin
    logic [LANES-1:0] ek, em;
    logic             efr, esy, ebz;

    tbl[0] = '{v: 2'b11, s: 2'b01, n: 2'b01, kill: 2'b10, marker: 2'b01, fr: 1'b1};
    tbl[1] = '{v: 2'b11, s: 2'b10, n: 2'b00, kill: 2'b00, marker: 2'b10, fr: 1'b1};
    tbl[2] = '{v: 2'b10, s: 2'b01, n: 2'b01, kill: 2'b00, marker: 2'b00, fr: 1'b0};
    tbl[3] = '{v: 2'b11, s: 2'b11, n: 2'b10, kill: 2'b10, marker: 2'b01, fr: 1'b1};
    tbl[4] = '{v: 2'b01, s: 2'b10, n: 2'b10, kill: 2'b00, marker: 2'b00, fr: 1'b0};
    tbl[5] = '{v: 2'b00, s: 2'b11, n: 2'b11, kill: 2'b00, marker: 2'b00, fr: 1'b0};
    tbl[6] = '{v: 2'b11, s: 2'b00, n: 2'b11, kill: 2'b00, marker: 2'b00, fr: 1'b0};
    tbl[7] = '{v: 2'b10, s: 2'b11, n: 2'b00, kill: 2'b00, marker: 2'b10, fr: 1'b1};

    RESET = 1'b0;
    drive('0, '0, '0, 1'b0);
    #2;
    chk("reset.sys",    bus.SYS,             1'b0);
    chk("reset.busy",   bus.Busy_OUT,        1'b0);
    chk("reset.lane",   bus.Serial_Lane_OUT, '0);
    chk("reset.freeze", bus.WANT_FREEZE,     1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    step();

    // Detection decode in IDLE; FLUSH keeps each vector from being latched
    for (int t = 0; t < 8; t++) begin
      drive(tbl[t].v, tbl[t].s, tbl[t].n, 1'b1);
      @(negedge CLK);
      chk($sformatf("tbl%0d.kill", t),   bus.Lane_Kill_OUT,   tbl[t].kill);
      chk($sformatf("tbl%0d.marker", t), bus.Lane_Marker_OUT, tbl[t].marker);
      chk($sformatf("tbl%0d.freeze", t), bus.WANT_FREEZE,     tbl[t].fr);
      chk($sformatf("tbl%0d.busy", t),   bus.Busy_OUT,        1'b0);
      step();
    end
    drive('0, '0, '0, 1'b0);
    step();

`ifndef ID_SYS_ACK_EN
    // Syscall in lane 0 with timed notify
    drive(2'b11, 2'b01, 2'b01, 1'b0);
    @(negedge CLK);
    chk("sc0.marker", bus.Lane_Marker_OUT, 2'b01);
    expect_ctl("sc0.det", 2'b10, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge CLK);
      expect_ctl($sformatf("sc0.drain%0d", i), 2'b11, 1'b1, 1'b0, 1'b1);
      chk("sc0.drain.marker", bus.Lane_Marker_OUT, 2'b00);
      step();
    end
    @(negedge CLK);
    expect_ctl("sc0.notify", 2'b11, 1'b1, 1'b1, 1'b1);
    step();
    @(negedge CLK);
    expect_ctl("sc0.release", 2'b11, 1'b0, 1'b0, 1'b1);
    step();
    drive(2'b11, 2'b00, 2'b00, 1'b0);
    @(negedge CLK);
    expect_ctl("sc0.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    chk("sc0.lane", bus.Serial_Lane_OUT, 0);
    step();
`else
    // Syscall with ack: early acks ignored, late ack ends NOTIFY
    drive(2'b11, 2'b01, 2'b01, 1'b0);
    ack_drv = 1'b1;
    @(negedge CLK);
    expect_ctl("ack.det", 2'b10, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge CLK);
      expect_ctl($sformatf("ack.drain%0d", i), 2'b11, 1'b1, 1'b0, 1'b1);
      step();
    end
    ack_drv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) ack_drv = 1'b1;
      @(negedge CLK);
      expect_ctl($sformatf("ack.notify%0d", i), 2'b11, 1'b1, 1'b1, 1'b1);
      step();
    end
    ack_drv = 1'b0;
    @(negedge CLK);
    expect_ctl("ack.release", 2'b11, 1'b0, 1'b0, 1'b1);
    step();
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    @(negedge CLK);
    expect_ctl("ack.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    step();
`endif

    // SC in lane 1: no notify phase
    drive(2'b11, 2'b10, 2'b00, 1'b0);
    @(negedge CLK);
    chk("sc1.marker", bus.Lane_Marker_OUT, 2'b10);
    expect_ctl("sc1.det", 2'b00, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge CLK);
      expect_ctl($sformatf("sc1.drain%0d", i), 2'b11, 1'b1, 1'b0, 1'b1);
      chk("sc1.lane", bus.Serial_Lane_OUT, 1);
      step();
    end
    @(negedge CLK);
    expect_ctl("sc1.release", 2'b11, 1'b0, 1'b0, 1'b1);
    step();
    drive(2'b11, 2'b00, 2'b00, 1'b0);
    @(negedge CLK);
    expect_ctl("sc1.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    chk("sc1.lane.hold", bus.Serial_Lane_OUT, 1);
    step();

    // FLUSH in the second DRAIN cycle
    drive(2'b11, 2'b01, 2'b01, 1'b0);
    step();
    drive(2'b11, 2'b00, 2'b00, 1'b0);
    @(negedge CLK);
    expect_ctl("fl.drain0", 2'b11, 1'b1, 1'b0, 1'b1);
    step();
    drive(2'b11, 2'b00, 2'b00, 1'b1);
    @(negedge CLK);
    expect_ctl("fl.drain1", 2'b11, 1'b1, 1'b0, 1'b1);
    step();
    drive(2'b11, 2'b00, 2'b00, 1'b0);
    @(negedge CLK);
    expect_ctl("fl.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    chk("fl.lane", bus.Serial_Lane_OUT, 0);
    step();

    // Asynchronous reset while in NOTIFY (syscall in lane 1)
    drive(2'b11, 2'b10, 2'b10, 1'b0);
    step();
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    repeat (DRAIN) step();
    @(negedge CLK);
    chk("rst.pre.sys",  bus.SYS,             1'b1);
    chk("rst.pre.lane", bus.Serial_Lane_OUT, 1);
    #1 RESET = 1'b0;
    #1;
    chk("rst.sys",  bus.SYS,             1'b0);
    chk("rst.busy", bus.Busy_OUT,        1'b0);
    chk("rst.lane", bus.Serial_Lane_OUT, 0);
    @(negedge CLK);
    RESET = 1'b1;
    step();

    // Randomized run against the phase-queue model
    q.delete();
    lane_m = '0;
    for (int c = 0; c < 3000; c++) begin
      drive(LANES'($urandom), LANES'($urandom), LANES'($urandom),
            ($urandom_range(0, 19) == 0));
`ifdef ID_SYS_ACK_EN
      ack_drv = ($urandom_range(0, 3) == 0);
`endif
      @(negedge CLK);
      model_out(ek, em, efr, esy, ebz);
      chk("rnd.kill",   bus.Lane_Kill_OUT,   ek);
      chk("rnd.marker", bus.Lane_Marker_OUT, em);
      chk("rnd.freeze", bus.WANT_FREEZE,     efr);
      chk("rnd.sys",    bus.SYS,             esy);
      chk("rnd.busy",   bus.Busy_OUT,        ebz);
      chk("rnd.lane",   bus.Serial_Lane_OUT, lane_m);
      @(posedge CLK);
      model_edge();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
